// File: rtl/sna_response_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sna_response_scheduler
// Description : Accepts AXI4-Lite read/write responses, arbitrates between
//               them round-robin, claims the lowest free VC and emits a
//               two-flit (header + tail) response packet to the NoC router.
// Revision    : 1.0 - initial release
// ============================================================================
module sna_response_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    input  logic [3:0]  pov_addr,
    input  logic [7:0]  is_allocatable,
    output logic [7:0]  vc_claim,
    output logic [36:0] flit_out,
    output logic        flit_valid,
    input  logic        flit_ready
);

    localparam logic [1:0] c_TYPE_HEAD = 2'b10;
    localparam logic [1:0] c_TYPE_TAIL = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // 0: read wins a tie, 1: write wins a tie
    logic        prio_q, prio_d;
    logic [31:0] payload_q, payload_d;
    logic        is_rd_q, is_rd_d;
    logic [2:0]  vc_q, vc_d;
    logic [3:0]  pov_q, pov_d;

    logic [2:0]  w_vc_sel;
    logic        w_grant_rd;
    logic        w_grant_wr;

    // Lowest-index free VC; scanning downward lets the lowest set bit win.
    always_comb begin
        w_vc_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (is_allocatable[i]) begin
                w_vc_sel = 3'(i);
            end
        end
    end

    // Next-state, arbitration, capture and flit output decode.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        payload_d  = payload_q;
        is_rd_d    = is_rd_q;
        vc_d       = vc_q;
        pov_d      = pov_q;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        rready     = 1'b0;
        bready     = 1'b0;
        vc_claim   = 8'd0;
        flit_valid = 1'b0;
        flit_out   = 37'd0;

        case (state_q)
            S_IDLE: begin
                // Reset suppresses the accept so no ready or claim leaks out.
                if (!rst && (is_allocatable != 8'd0)) begin
                    w_grant_rd = rvalid && (!bvalid || !prio_q);
                    w_grant_wr = bvalid && (!rvalid ||  prio_q);
                end
                if (w_grant_rd || w_grant_wr) begin
                    rready    = w_grant_rd;
                    bready    = w_grant_wr;
                    vc_claim  = 8'd1 << w_vc_sel;
                    payload_d = w_grant_rd ? rdata : {30'd0, bresp};
                    is_rd_d   = w_grant_rd;
                    vc_d      = w_vc_sel;
                    pov_d     = pov_addr;
                    // Hand the tie-break to whichever side did not win.
                    prio_d    = w_grant_rd;
                    state_d   = S_HEAD;
                end
            end
            S_HEAD: begin
                flit_valid = 1'b1;
                flit_out   = {c_TYPE_HEAD, vc_q, pov_q, 27'd0, is_rd_q};
                if (flit_ready) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                flit_valid = 1'b1;
                flit_out   = {c_TYPE_TAIL, vc_q, payload_q};
                if (flit_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-packet registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            payload_q <= 32'd0;
            is_rd_q   <= 1'b0;
            vc_q      <= 3'd0;
            pov_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            payload_q <= payload_d;
            is_rd_q   <= is_rd_d;
            vc_q      <= vc_d;
            pov_q     <= pov_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/sna_response_scheduler.md
SNA_RESPONSE_SCHEDULER -- requirements
Module: SNA_response_scheduler

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 rdata  input  32  AXI4-Lite read data from the slave.
REQ-005 rvalid  input  1  read response valid.
REQ-006 rready  output  1  read response accepted, high only in the accept cycle.
REQ-007 bresp  input  2  AXI4-Lite write response code.
REQ-008 bvalid  input  1  write response valid.
REQ-009 bready  output  1  write response accepted, high only in the accept cycle.
REQ-010 pov_addr  input  4  NoC destination (point-of-view address) for the response packet.
REQ-011 is_allocatable  input  8  free-VC mask, bit i = VC i free; any number of bits may be set.
REQ-012 vc_claim  output  8  one-hot pulse, one cycle, marks the VC taken at accept.
REQ-013 flit_out  output  37  flit to the router input port.
REQ-014 flit_valid  output  1  flit_out holds a valid flit.
REQ-015 flit_ready  input  1  router consumed flit_out this cycle when flit_valid=1.

Function
REQ-016 Flit format: [36:35] type (10 header, 01 tail); [34:32] VC index; header [31:28] pov_addr, [27:1] zero, [0] 1=read resp / 0=write resp; tail [31:0] payload.
REQ-017 Tail payload: rdata for read responses; {30'b0, bresp} for write responses.
REQ-018 FSM states: IDLE, HEAD, TAIL; reset state IDLE.
REQ-019 IDLE: accept occurs when (rvalid or bvalid) and is_allocatable != 0; otherwise stay IDLE with rready=bready=0.
REQ-020 Arbitration: only one requester valid -> it wins; both valid -> round-robin via 1-bit priority register (reset value = read first); priority flips to the loser after each accept.
REQ-021 VC selection: lowest-index set bit of is_allocatable in the accept cycle.
REQ-022 Accept cycle: winner's ready=1 (combinational from valid, mask and state); vc_claim = one-hot of chosen VC; register payload, type bit, VC index, pov_addr; next state HEAD.
REQ-023 HEAD: flit_valid=1, flit_out=header; flit_ready=1 -> TAIL, else hold all outputs stable.
REQ-024 TAIL: flit_valid=1, flit_out=tail; flit_ready=1 -> IDLE, else hold.
REQ-025 Captured fields stay constant from accept until tail handshake; changes on rdata/bresp/pov_addr/is_allocatable meanwhile have no effect.
REQ-026 No new accept in HEAD or TAIL; rready=bready=0 there regardless of valid.
REQ-027 Latency: header valid one cycle after accept; minimum 3 cycles per response (accept, header, tail) with flit_ready held high.
REQ-028 is_allocatable=0 with pending valid: wait in IDLE, no ready, no vc_claim, priority unchanged.
REQ-029 flit_out = 0 whenever flit_valid=0.

Reset
REQ-030 rst=1 for one edge forces IDLE, rready=bready=0, vc_claim=0, flit_valid=0, flit_out=0, priority=read.
REQ-031 Reset mid-packet (HEAD or TAIL) discards the packet; no tail is sent after reset; claimed VC is not released by this block.
REQ-032 Reset overrides any simultaneous accept or handshake in the same cycle.

Verification
REQ-033 Read only: rvalid=1, rdata=32'hDEADBEEF, pov_addr=4'h5, mask=8'b00000100, flit_ready=1 -> rready pulse, vc_claim=8'b00000100, header 37'b10_010_0101_0..0_1, then tail {2'b01,3'b010,32'hDEADBEEF}.
REQ-034 Write only: bvalid=1, bresp=2'b10, mask=8'b10010000 -> bready pulse, VC 4 chosen, header bit0=0, tail payload 32'h00000002.
REQ-035 Simultaneous rvalid and bvalid held 4 responses -> grant order read, write, read, write; 12 cycles with flit_ready=1.
REQ-036 Backpressure: flit_ready=0 for 5 cycles in HEAD then in TAIL -> flit_out stable, no rready/bready, packet completes after release.
REQ-037 Mask=0 with rvalid=1 for 10 cycles -> no rready, no flit; mask=8'h01 -> accept next cycle on VC 0.
REQ-038 rst asserted in TAIL -> next cycle flit_valid=0, IDLE, priority=read; pending bvalid and rvalid -> read accepted first.
